// File: rtl/cam_capture_scaled.sv
// Camera byte-stream capture: folds RGB565 byte pairs into RGB444/RGB332 words,
// decimates and clips to a fixed frame, and freezes the buffer on a photo request.
module cam_capture_scaled #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int DECIM = 1
) (
    input  logic          CAM_PCLK,
    input  logic          rst,
    input  logic          CAM_VSYNC,
    input  logic          CAM_HREF,
    input  logic [7:0]    CAM_px_data,
    input  logic          Photo_button,
    input  logic          Video_button,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          frame_err,
    output logic          frozen
);

    localparam int          DSH        = (DECIM == 4) ? 2 : (DECIM == 2) ? 1 : 0;
    localparam logic [11:0] DMASK      = 12'(DECIM - 1);
    localparam logic [11:0] IMG_W12    = 12'(IMG_W);
    localparam logic [11:0] IMG_H12    = 12'(IMG_H);
    localparam logic [11:0] FULL_LINES = 12'(IMG_H * DECIM);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        BYTE_HI,
        BYTE_LO,
        FROZEN
    } state_t;

    state_t state, state_n;

    logic          vsync_q;
    logic          href_q;
    logic          photo_q;
    logic [7:0]    byte_hi_p0;
    logic [11:0]   pix_cnt;
    logic [11:0]   line_cnt;
    logic [AW-1:0] col_cnt;
    logic [AW-1:0] row_base;
    logic [AW-1:0] addr_p1;
    logic [DW-1:0] data_p1;
    logic          vld_p1;

    logic take_hi, form_px, line_end, frame_end;
    logic vsync_rise, vsync_fall, href_rise;
    logic keep_px, row_adv;
    logic [11:0] line_nxt;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [DW-1:0] pack_px(input logic [7:0] b1, input logic [7:0] b2);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = b1[7:3];
        g = {b1[2:0], b2[7:5]};
        b = b2[4:0];
        if (DW == 8)
            return DW'({r[4:2], g[5:3], b[4:3]});
        else
            return DW'({r[4:1], g[5:2], b[4:1]});
    endfunction

    assign vsync_rise = CAM_VSYNC & ~vsync_q;
    assign vsync_fall = ~CAM_VSYNC & vsync_q;
    assign href_rise  = CAM_HREF & ~href_q;

    assign keep_px  = ((pix_cnt & DMASK) == 12'd0) && ((line_cnt & DMASK) == 12'd0) &&
                      ((pix_cnt >> DSH) < IMG_W12) && ((line_cnt >> DSH) < IMG_H12);
    assign line_nxt = sat_inc(line_cnt);
    // The row base only steps when the line just finished starts a new stored row.
    assign row_adv  = ((line_nxt & DMASK) == 12'd0) && ((line_nxt >> DSH) < IMG_H12);

    always_ff @(posedge CAM_PCLK) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        take_hi   = 1'b0;
        form_px   = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_fall) state_n = WAIT_LINE;
            end
            WAIT_LINE: begin
                if (vsync_rise) begin
                    frame_end = 1'b1;
                end else if (href_rise) begin
                    take_hi = 1'b1;
                    state_n = BYTE_LO;
                end
            end
            BYTE_LO: begin
                if (vsync_rise) begin
                    frame_end = 1'b1;
                end else if (CAM_HREF) begin
                    form_px = 1'b1;
                    state_n = BYTE_HI;
                end else begin
                    line_end = 1'b1;
                    state_n  = WAIT_LINE;
                end
            end
            BYTE_HI: begin
                if (vsync_rise) begin
                    frame_end = 1'b1;
                end else if (CAM_HREF) begin
                    take_hi = 1'b1;
                    state_n = BYTE_LO;
                end else begin
                    line_end = 1'b1;
                    state_n  = WAIT_LINE;
                end
            end
            FROZEN: begin
                if (Video_button) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (frame_end) state_n = photo_q ? FROZEN : IDLE;
    end

    always_ff @(posedge CAM_PCLK) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            photo_q    <= 1'b0;
            byte_hi_p0 <= '0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            col_cnt    <= '0;
            row_base   <= '0;
            addr_p1    <= '0;
            data_p1    <= '0;
            vld_p1     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vsync_q    <= CAM_VSYNC;
            href_q     <= CAM_HREF;
            vld_p1     <= 1'b0;
            frame_done <= 1'b0;

            if (Video_button)
                photo_q <= 1'b0;
            else if (Photo_button && state != FROZEN)
                photo_q <= 1'b1;

            // stage p0: first byte of the pair held until its partner arrives
            if (take_hi) byte_hi_p0 <= CAM_px_data;

            // stage p1: assembled pixel, address and strobe presented to the RAM
            if (form_px) begin
                pix_cnt <= sat_inc(pix_cnt);
                if (keep_px) begin
                    vld_p1  <= 1'b1;
                    addr_p1 <= row_base + col_cnt;
                    data_p1 <= pack_px(byte_hi_p0, CAM_px_data);
                    col_cnt <= col_cnt + AW'(1);
                end
            end

            if (line_end) begin
                pix_cnt  <= '0;
                col_cnt  <= '0;
                line_cnt <= line_nxt;
                if (row_adv) row_base <= row_base + AW'(IMG_W);
            end

            if (frame_end) begin
                frame_done <= 1'b1;
                frame_err  <= (line_cnt != FULL_LINES);
            end

            if (state == IDLE || state == FROZEN) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                col_cnt  <= '0;
                row_base <= '0;
            end
        end
    end

    assign DP_RAM_addr_in = addr_p1;
    assign DP_RAM_data_in = data_p1;
    assign DP_RAM_regW    = vld_p1;
    assign frozen         = (state == FROZEN);

endmodule

// File: tb/tb_cam_capture_scaled.sv
// Scoreboard bench for cam_capture_scaled: a full-size RGB444 instance, a decimating
// RGB332 instance and a small 8x6 instance share one camera stimulus.
module tb_cam_capture_scaled;

    logic       clk = 1'b0;
    logic       rst, vs, href, photo, video;
    logic [7:0] px;

    logic [14:0] a1; logic [11:0] d1; logic w1, fd1, fe1, fz1;
    logic [14:0] a2; logic [7:0]  d2; logic w2, fd2, fe2, fz2;
    logic [5:0]  a3; logic [11:0] d3; logic w3, fd3, fe3, fz3;

    always #5 clk = ~clk;

    cam_capture_scaled dut1 (
        .CAM_PCLK(clk), .rst(rst), .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_px_data(px),
        .Photo_button(photo), .Video_button(video),
        .DP_RAM_addr_in(a1), .DP_RAM_data_in(d1), .DP_RAM_regW(w1),
        .frame_done(fd1), .frame_err(fe1), .frozen(fz1));

    cam_capture_scaled #(.AW(15), .DW(8), .IMG_W(80), .IMG_H(60), .DECIM(2)) dut2 (
        .CAM_PCLK(clk), .rst(rst), .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_px_data(px),
        .Photo_button(photo), .Video_button(video),
        .DP_RAM_addr_in(a2), .DP_RAM_data_in(d2), .DP_RAM_regW(w2),
        .frame_done(fd2), .frame_err(fe2), .frozen(fz2));

    cam_capture_scaled #(.AW(6), .DW(12), .IMG_W(8), .IMG_H(6), .DECIM(1)) dut3 (
        .CAM_PCLK(clk), .rst(rst), .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_px_data(px),
        .Photo_button(photo), .Video_button(video),
        .DP_RAM_addr_in(a3), .DP_RAM_data_in(d3), .DP_RAM_regW(w3),
        .frame_done(fd3), .frame_err(fe3), .frozen(fz3));

    int tests_run = 0;
    int tests_failed = 0;

    bit mon1 = 0, mon2 = 0, mon3 = 0;
    int q1a[$]; logic [11:0] q1d[$];
    int q2a[$]; logic [7:0]  q2d[$];
    int q3a[$]; logic [11:0] q3d[$];

    int wcnt1 = 0, wcnt2 = 0, wcnt3 = 0;
    int done1 = 0, done2 = 0, done3 = 0;
    int last1 = -1, last2 = -1, last3 = -1;
    logic [11:0] first_d1 = '0;
    logic [7:0]  d2_at80 = '0;
    int ea1, ea2, ea3;
    logic [11:0] ed1, ed3;
    logic [7:0]  ed2;

    function automatic logic [7:0] patt(int seed, int l, int i);
        if (seed == 1 && l == 0 && i == 0) return 8'hF8;
        if (seed == 1 && l == 0 && i == 1) return 8'h1F;
        if (seed == 1 && l == 2 && i == 0) return 8'h07;
        if (seed == 1 && l == 2 && i == 1) return 8'hE0;
        return 8'((seed * 37 + l * 11 + i * 29 + 3) & 255);
    endfunction

    function automatic logic [11:0] exp12(logic [7:0] b1, logic [7:0] b2);
        logic [4:0] r; logic [5:0] g; logic [4:0] b;
        r = b1[7:3]; g = {b1[2:0], b2[7:5]}; b = b2[4:0];
        return {r[4:1], g[5:2], b[4:1]};
    endfunction

    function automatic logic [7:0] exp8(logic [7:0] b1, logic [7:0] b2);
        logic [4:0] r; logic [5:0] g; logic [4:0] b;
        r = b1[7:3]; g = {b1[2:0], b2[7:5]}; b = b2[4:0];
        return {r[4:2], g[5:3], b[4:3]};
    endfunction

    // Monitors: pop the expected write and compare when a strobe appears.
    always @(negedge clk) begin
        if (fd1 === 1'b1) done1++;
        if (w1 === 1'b1) begin
            if (wcnt1 == 0) first_d1 = d1;
            wcnt1++;
            last1 = int'(a1);
            if (mon1) begin
                tests_run++;
                if (q1a.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wr1_extra: got addr=%0d data=%h, expected no write", a1, d1);
                end else begin
                    ea1 = q1a.pop_front(); ed1 = q1d.pop_front();
                    if (int'(a1) !== ea1 || d1 !== ed1) begin
                        tests_failed++;
                        $display("FAIL wr1: got addr=%0d data=%h, expected addr=%0d data=%h", a1, d1, ea1, ed1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fd2 === 1'b1) done2++;
        if (w2 === 1'b1) begin
            if (a2 == 15'd80) d2_at80 = d2;
            wcnt2++;
            last2 = int'(a2);
            if (mon2) begin
                tests_run++;
                if (q2a.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wr2_extra: got addr=%0d data=%h, expected no write", a2, d2);
                end else begin
                    ea2 = q2a.pop_front(); ed2 = q2d.pop_front();
                    if (int'(a2) !== ea2 || d2 !== ed2) begin
                        tests_failed++;
                        $display("FAIL wr2: got addr=%0d data=%h, expected addr=%0d data=%h", a2, d2, ea2, ed2);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fd3 === 1'b1) done3++;
        if (w3 === 1'b1) begin
            wcnt3++;
            last3 = int'(a3);
            if (mon3) begin
                tests_run++;
                if (q3a.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wr3_extra: got addr=%0d data=%h, expected no write", a3, d3);
                end else begin
                    ea3 = q3a.pop_front(); ed3 = q3d.pop_front();
                    if (int'(a3) !== ea3 || d3 !== ed3) begin
                        tests_failed++;
                        $display("FAIL wr3: got addr=%0d data=%h, expected addr=%0d data=%h", a3, d3, ea3, ed3);
                    end
                end
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_px(int l, int p, logic [7:0] b1, logic [7:0] b2);
        if (mon1 && l < 120 && p < 160) begin
            q1a.push_back(l * 160 + p); q1d.push_back(exp12(b1, b2));
        end
        if (mon2 && l % 2 == 0 && p % 2 == 0 && l / 2 < 60 && p / 2 < 80) begin
            q2a.push_back((l / 2) * 80 + p / 2); q2d.push_back(exp8(b1, b2));
        end
        if (mon3 && l < 6 && p < 8) begin
            q3a.push_back(l * 8 + p); q3d.push_back(exp12(b1, b2));
        end
    endtask

    task automatic drive_line(int l, int n, int seed, bit expect_wr, bit photo_pulse);
        logic [7:0] b, prev;
        prev = 8'h00;
        for (int i = 0; i < n; i++) begin
            photo = (i == 0) && photo_pulse;
            href  = 1'b1;
            b     = patt(seed, l, i);
            px    = b;
            if (i % 2 == 1 && expect_wr) model_px(l, i / 2, prev, b);
            prev = b;
            tick();
        end
        photo = 1'b0;
        href  = 1'b0;
        px    = 8'h00;
        repeat (2) tick();
    endtask

    task automatic run_frame(int nlines, int nbytes, int first_nbytes, bit expect_wr,
                             int photo_line, int seed);
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < nlines; l++)
            drive_line(l, (l == 0) ? first_nbytes : nbytes, seed, expect_wr, l == photo_line);
        vs = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; vs = 1'b1; href = 1'b0; px = 8'h00; photo = 1'b0; video = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({w1, fd1, fe1, fz1} !== 4'b0000 || a1 !== 15'd0 || d1 !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_dut1: got regW=%b done=%b err=%b frozen=%b addr=%0d data=%h, expected all 0",
                     w1, fd1, fe1, fz1, a1, d1);
        end
        tests_run++;
        if ({w3, fd3, fe3, fz3} !== 4'b0000 || a3 !== 6'd0 || d3 !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_dut3: got regW=%b done=%b err=%b frozen=%b addr=%0d data=%h, expected all 0",
                     w3, fd3, fe3, fz3, a3, d3);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        int w1s, w2s, dn1s, dn2s;
        mon1 = 1; mon2 = 1;
        w1s = wcnt1; w2s = wcnt2; dn1s = done1; dn2s = done2;
        run_frame(120, 320, 320, 1, -1, 1);
        tests_run++;
        if (wcnt1 - w1s != 19200) begin tests_failed++;
            $display("FAIL full_count: got %0d writes, expected 19200", wcnt1 - w1s); end
        tests_run++;
        if (last1 != 19199) begin tests_failed++;
            $display("FAIL full_last_addr: got %0d, expected 19199", last1); end
        tests_run++;
        if (first_d1 !== 12'hF0F) begin tests_failed++;
            $display("FAIL full_first_data: got %h, expected f0f", first_d1); end
        tests_run++;
        if (done1 - dn1s != 1 || fe1 !== 1'b0) begin tests_failed++;
            $display("FAIL full_done_err: got done=%0d err=%b, expected done=1 err=0", done1 - dn1s, fe1); end
        tests_run++;
        if (wcnt2 - w2s != 4800 || last2 != 4799) begin tests_failed++;
            $display("FAIL decim_count: got %0d writes last=%0d, expected 4800 last=4799", wcnt2 - w2s, last2); end
        tests_run++;
        if (d2_at80 !== 8'h1C) begin tests_failed++;
            $display("FAIL decim_data: got %h at addr 80, expected 1c", d2_at80); end
        tests_run++;
        if (done2 - dn2s != 1 || fe2 !== 1'b0) begin tests_failed++;
            $display("FAIL decim_done_err: got done=%0d err=%b, expected done=1 err=0", done2 - dn2s, fe2); end
        tests_run++;
        if (q1a.size() != 0 || q2a.size() != 0) begin tests_failed++;
            $display("FAIL full_missing: got %0d/%0d writes outstanding, expected 0/0", q1a.size(), q2a.size()); end
        mon1 = 0; mon2 = 0;
    endtask

    task automatic test_photo();
        int ws, dns;
        mon3 = 1;
        ws = wcnt3;
        run_frame(6, 16, 16, 1, 3, 2);
        tests_run++;
        if (wcnt3 - ws != 48 || last3 != 47 || fz3 !== 1'b1) begin tests_failed++;
            $display("FAIL photo_freeze: got writes=%0d last=%0d frozen=%b, expected 48 47 1",
                     wcnt3 - ws, last3, fz3); end
        ws = wcnt3; dns = done3;
        run_frame(6, 16, 16, 0, 1, 3);
        run_frame(6, 16, 16, 0, -1, 4);
        tests_run++;
        if (wcnt3 - ws != 0 || done3 - dns != 0 || fz3 !== 1'b1) begin tests_failed++;
            $display("FAIL photo_hold: got writes=%0d done=%0d frozen=%b, expected 0 0 1",
                     wcnt3 - ws, done3 - dns, fz3); end
        photo = 1'b1; video = 1'b1;
        tick();
        photo = 1'b0; video = 1'b0;
        tick();
        tests_run++;
        if (fz3 !== 1'b0) begin tests_failed++;
            $display("FAIL photo_release: got frozen=%b, expected 0", fz3); end
        ws = wcnt3;
        run_frame(6, 16, 16, 1, -1, 5);
        tests_run++;
        if (wcnt3 - ws != 48 || fz3 !== 1'b0 || q3a.size() != 0) begin tests_failed++;
            $display("FAIL photo_resume: got writes=%0d frozen=%b outstanding=%0d, expected 48 0 0",
                     wcnt3 - ws, fz3, q3a.size()); end
    endtask

    task automatic test_odd_bytes();
        int ws;
        ws = wcnt3;
        run_frame(6, 16, 17, 1, -1, 6);
        tests_run++;
        if (wcnt3 - ws != 48 || fe3 !== 1'b0 || q3a.size() != 0) begin tests_failed++;
            $display("FAIL odd_bytes: got writes=%0d err=%b outstanding=%0d, expected 48 0 0",
                     wcnt3 - ws, fe3, q3a.size()); end
    endtask

    task automatic test_clip();
        int ws;
        ws = wcnt3;
        run_frame(10, 20, 20, 1, -1, 7);
        tests_run++;
        if (wcnt3 - ws != 48 || last3 != 47 || fe3 !== 1'b1) begin tests_failed++;
            $display("FAIL clip_over: got writes=%0d last=%0d err=%b, expected 48 47 1",
                     wcnt3 - ws, last3, fe3); end
        ws = wcnt3;
        run_frame(4, 16, 16, 1, -1, 8);
        tests_run++;
        if (wcnt3 - ws != 32 || last3 != 31 || fe3 !== 1'b1 || q3a.size() != 0) begin tests_failed++;
            $display("FAIL clip_under: got writes=%0d last=%0d err=%b outstanding=%0d, expected 32 31 1 0",
                     wcnt3 - ws, last3, fe3, q3a.size()); end
    endtask

    task automatic test_mid_line_reset();
        int ws;
        vs = 1'b1; repeat (3) tick();
        vs = 1'b0; repeat (2) tick();
        drive_line(0, 16, 9, 1, 0);
        href = 1'b1; px = patt(9, 1, 0);
        tick();
        px = patt(9, 1, 1); rst = 1'b1;
        tick();
        tests_run++;
        if ({w3, fd3, fe3, fz3} !== 4'b0000 || a3 !== 6'd0 || d3 !== 12'd0) begin tests_failed++;
            $display("FAIL midline_reset: got regW=%b done=%b err=%b frozen=%b addr=%0d data=%h, expected all 0",
                     w3, fd3, fe3, fz3, a3, d3); end
        rst = 1'b0;
        ws = wcnt3;
        for (int i = 0; i < 9; i++) begin
            px = 8'($urandom_range(0, 255));
            tick();
        end
        href = 1'b0; repeat (2) tick();
        drive_line(1, 16, 9, 0, 0);
        tests_run++;
        if (wcnt3 - ws != 0) begin tests_failed++;
            $display("FAIL midline_nowrite: got %0d writes, expected 0", wcnt3 - ws); end
        ws = wcnt3;
        run_frame(6, 16, 16, 1, -1, 10);
        tests_run++;
        if (wcnt3 - ws != 48 || fe3 !== 1'b0 || q3a.size() != 0) begin tests_failed++;
            $display("FAIL midline_resume: got writes=%0d err=%b outstanding=%0d, expected 48 0 0",
                     wcnt3 - ws, fe3, q3a.size()); end
        mon3 = 0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_photo();
        test_odd_bytes();
        test_clip();
        test_mid_line_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
